pll_hs_rst_seq: RTL and testbench
=================================

// Module: pll_hs_rst_seq
// PURPOSE
//  Reset/lock sequencer for the MIPI DSI HS-clock PLL. Drives the PLL's pll_rst and rstodiv inputs.
//  Qualifies the asynchronous pll_lock output, then releases hs_rst to the DSI TX serialiser/lane logic.
//  On loss of lock it restarts the sequence; on repeated lock timeouts it parks in a sticky FAIL state.
//  Runs on the free-running board clock that also feeds the PLL's clkin1, never on a PLL output.
// PARAMETERS
//  RST_CYCLES      64     cycles pll_rst held high per attempt (>=1)
//  LOCK_TIMEOUT    65000  max cycles waiting for synced lock per attempt (1 ms @ 65 MHz)
//  LOCK_STABLE     256    consecutive synced-lock cycles required before proceeding
//  RSTODIV_CYCLES  8      width of rstodiv pulse (output-divider phase realign)
//  MAX_RETRY       4      timeouts tolerated before FAIL (1..15)
// PORTS
//  clk            in   1  board clock (same source as PLL clkin1)
//  rst            in   1  synchronous, active-high reset
//  restart        in   1  1-cycle pulse, forces new sequence from any state, clears retry count
//  pll_lock       in   1  PLL lock, asynchronous to clk
//  pll_rst        out  1  to PLL RST
//  rstodiv        out  1  to PLL RSTODIV_PHASE
//  hs_rst         out  1  active-high reset for HS-clock-domain logic
//  ready          out  1  PLL locked, stable and divider aligned
//  fail           out  1  sticky: MAX_RETRY lock timeouts occurred
//  lock_lost_cnt  out  8  loss-of-lock events in RUN, saturates at 255
// BEHAVIOUR
//  Reset values: pll_rst=1, rstodiv=0, hs_rst=1, ready=0, fail=0, lock_lost_cnt=0, state=S_RESET, counters=0.
//  Reset timing: rst is synchronous and active-high and overrides everything.
//  Synchronizer: pll_lock passes a 2-FF synchronizer -> lock_s. All decisions use lock_s.
//  Register outputs: every output is a registered decode of the next state, so it changes on the
//   same edge as the state register.
//  States:
//   S_RESET: pll_rst=1, hs_rst=1.
//    Exit: after RST_CYCLES cycles -> S_WAIT_LOCK. First cycle of pll_rst=0 is the RST_CYCLES+1-th after entry.
//   S_WAIT_LOCK: pll_rst=0.
//    lock_s=1 -> S_STABLE, with stable_cnt=1.
//    Timeout: timeout_cnt reaches LOCK_TIMEOUT -> retry_cnt++.
//     retry_cnt==MAX_RETRY -> S_FAIL; else -> S_RESET.
//   S_STABLE: lock_s=1 increments stable_cnt.
//    stable_cnt==LOCK_STABLE -> S_ODIV.
//    lock_s=0 -> S_WAIT_LOCK, clearing stable_cnt only. Timeout counter keeps running (no reset per glitch).
//   S_ODIV: rstodiv=1 for exactly RSTODIV_CYCLES cycles, then -> S_RUN.
//    lock_s=0 here -> S_RESET. This is not counted in lock_lost_cnt.
//   S_RUN: hs_rst=0, ready=1, retry_cnt cleared.
//    lock_s=0 for one cycle -> S_RESET, lock_lost_cnt++ (saturating).
//    hs_rst and ready reassert on the edge the state leaves S_RUN.
//   S_FAIL: pll_rst=1, hs_rst=1, fail=1. Exit only via rst or restart.
//  hs_rst rule: hs_rst=1 in every state except S_RUN; ready == ~hs_rst.
//  Restart: restart clears retry_cnt and timeout_cnt and forces -> S_RESET. fail clears on restart.
//  Simultaneous events:
//   restart in the same cycle as lock loss: restart takes priority (-> S_RESET, no lock_lost_cnt increment).
//   restart in the same cycle as a timeout: restart takes priority (retry_cnt stays 0).
//  Counter widths: each counter is $clog2(param+1) bits. No counter wraps. All compares are equality
//   against the parameter value.
// STRUCTURE
//  pll_seq_pkg:
//   state enum: S_RESET, S_WAIT_LOCK, S_STABLE, S_ODIV, S_RUN, S_FAIL; 3-bit binary encoding.
//   LOST_CNT_W = 8.
//  Sub-module sync_2ff: generic 1-bit 2-flop synchronizer with async-reg attributes.
//   Reset value 0. Reused for other async status bits.
//  Top: one FSM process plus counters. No other hierarchy.
// TESTING
//  1. Nominal lock: bench params RST_CYCLES=4, LOCK_STABLE=8, RSTODIV_CYCLES=2. Release rst; pll_lock=1 from cycle 10.
//     Expect: pll_rst=1 for exactly 4 cycles; rstodiv high exactly 2 cycles; ready=1 with
//     hs_rst=0 at 2(sync)+8+2 cycles after lock seen.
//  2. Glitch during qualify: drop pll_lock for 3 cycles at stable_cnt=5.
//     Expect: return to S_WAIT_LOCK and stable_cnt restarts. ready delayed by the full LOCK_STABLE after relock.
//  3. Loss in RUN: deassert pll_lock in S_RUN.
//     Expect: hs_rst=1, ready=0 within 3 cycles; pll_rst pulses again; lock_lost_cnt 0->1.
//     Repeat 300x -> lock_lost_cnt holds 255.
//  4. Timeout/fail: LOCK_TIMEOUT=20, MAX_RETRY=3, pll_lock held 0.
//     Expect: 3 reset pulses, then fail=1 and pll_rst=1 permanently.
//     Then pulse restart -> fail=0 and a new sequence starts.
//  5. Priority: restart coincident with lock loss in RUN -> S_RESET, lock_lost_cnt unchanged.
//     rst asserted mid-S_ODIV -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the HS-clock PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_ODIV      = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam int unsigned LOST_CNT_W = 8;

  typedef struct packed {
    logic pll_rst;
    logic rstodiv;
    logic hs_rst;
    logic ready;
    logic fail;
  } outs_t;

  localparam outs_t OUTS_RESET = '{pll_rst: 1'b1, rstodiv: 1'b0, hs_rst: 1'b1,
                                   ready: 1'b0, fail: 1'b0};

  // Output decode of a state; applied to the next state so outputs move with the state register.
  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o.pll_rst = (s == S_RESET) || (s == S_FAIL);
    o.rstodiv = (s == S_ODIV);
    o.hs_rst  = (s != S_RUN);
    o.ready   = (s == S_RUN);
    o.fail    = (s == S_FAIL);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  // Two back-to-back flops; both clear to 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/pll_hs_rst_seq.sv
// Reset/lock sequencer for the MIPI DSI HS-clock PLL: pulses pll_rst, qualifies lock,
// realigns the output divider and then releases hs_rst. Runs on the board clock.
module pll_hs_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT   = 65000,
  parameter int unsigned LOCK_STABLE    = 256,
  parameter int unsigned RSTODIV_CYCLES = 8,
  parameter int unsigned MAX_RETRY      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic                  rstodiv,
  output logic                  hs_rst,
  output logic                  ready,
  output logic                  fail,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned ODV_W = $clog2(RSTODIV_CYCLES + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_END = RST_W'(RST_CYCLES);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0] STB_END = STB_W'(LOCK_STABLE);
  localparam logic [ODV_W-1:0] ODV_END = ODV_W'(RSTODIV_CYCLES);
  localparam logic [RTY_W-1:0] RTY_END = RTY_W'(MAX_RETRY);

  logic lock_s;

  state_t state, state_n;
  outs_t  outs_q;

  logic [RST_W-1:0]      rst_cnt, rst_cnt_n, rst_inc;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_n, tmo_inc;
  logic [STB_W-1:0]      stb_cnt, stb_cnt_n, stb_inc;
  logic [ODV_W-1:0]      odv_cnt, odv_cnt_n, odv_inc;
  logic [RTY_W-1:0]      rty_cnt, rty_cnt_n, rty_inc;
  logic [LOST_CNT_W-1:0] lost_cnt, lost_cnt_n;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign rst_inc = rst_cnt + RST_W'(1);
  assign tmo_inc = tmo_cnt + TMO_W'(1);
  assign stb_inc = stb_cnt + STB_W'(1);
  assign odv_inc = odv_cnt + ODV_W'(1);
  assign rty_inc = rty_cnt + RTY_W'(1);

  // Next-state and counter update. Each counter exits its state when the incremented
  // value equals the parameter, so it never exceeds the parameter and never wraps.
  // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
  always_comb begin
    state_n    = state;
    rst_cnt_n  = rst_cnt;
    tmo_cnt_n  = tmo_cnt;
    stb_cnt_n  = stb_cnt;
    odv_cnt_n  = odv_cnt;
    rty_cnt_n  = rty_cnt;
    lost_cnt_n = lost_cnt;
    if (restart) begin
      state_n   = S_RESET;
      rst_cnt_n = '0;
      tmo_cnt_n = '0;
      stb_cnt_n = '0;
      odv_cnt_n = '0;
      rty_cnt_n = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (rst_inc == RST_END) begin
            state_n   = S_WAIT_LOCK;
            rst_cnt_n = '0;
          end else begin
            rst_cnt_n = rst_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            if (LOCK_STABLE == 1) begin
              state_n   = S_ODIV;
              stb_cnt_n = '0;
              tmo_cnt_n = '0;
            end else begin
              state_n   = S_STABLE;
              stb_cnt_n = STB_W'(1);
            end
          end else if (tmo_inc == TMO_END) begin
            tmo_cnt_n = '0;
            rty_cnt_n = rty_inc;
            state_n   = (rty_inc == RTY_END) ? S_FAIL : S_RESET;
          end else begin
            tmo_cnt_n = tmo_inc;
          end
        end
        S_STABLE: begin
          // A glitch drops back to WAIT_LOCK without resetting the attempt timeout.
          if (!lock_s) begin
            state_n   = S_WAIT_LOCK;
            stb_cnt_n = '0;
          end else if (stb_inc == STB_END) begin
            state_n   = S_ODIV;
            stb_cnt_n = '0;
            tmo_cnt_n = '0;
          end else begin
            stb_cnt_n = stb_inc;
          end
        end
        S_ODIV: begin
          if (!lock_s) begin
            state_n   = S_RESET;
            odv_cnt_n = '0;
          end else if (odv_inc == ODV_END) begin
            state_n   = S_RUN;
            odv_cnt_n = '0;
          end else begin
            odv_cnt_n = odv_inc;
          end
        end
        S_RUN: begin
          rty_cnt_n = '0;
          if (!lock_s) begin
            state_n = S_RESET;
            if (lost_cnt != '1) lost_cnt_n = lost_cnt + LOST_CNT_W'(1);
          end
        end
        S_FAIL: begin
          state_n = S_FAIL;
        end
        default: begin
          state_n = S_RESET;
        end
      endcase
    end
  end

  // State, counters and registered output decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      outs_q   <= OUTS_RESET;
      rst_cnt  <= '0;
      tmo_cnt  <= '0;
      stb_cnt  <= '0;
      odv_cnt  <= '0;
      rty_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      state    <= state_n;
      outs_q   <= decode_outs(state_n);
      rst_cnt  <= rst_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
      stb_cnt  <= stb_cnt_n;
      odv_cnt  <= odv_cnt_n;
      rty_cnt  <= rty_cnt_n;
      lost_cnt <= lost_cnt_n;
    end
  end

  assign pll_rst       = outs_q.pll_rst;
  assign rstodiv       = outs_q.rstodiv;
  assign hs_rst        = outs_q.hs_rst;
  assign ready         = outs_q.ready;
  assign fail          = outs_q.fail;
  assign lock_lost_cnt = lost_cnt;

endmodule

// File: tb/tb_pll_hs_rst_seq.sv
// Directed self-checking bench for pll_hs_rst_seq with short sequencing parameters.
module tb_pll_hs_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       pll_lock;
  logic       pll_rst;
  logic       rstodiv;
  logic       hs_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lock_lost_cnt;

  int checks = 0;
  int errors = 0;

  pll_hs_rst_seq #(
    .RST_CYCLES     (4),
    .LOCK_TIMEOUT   (20),
    .LOCK_STABLE    (8),
    .RSTODIV_CYCLES (2),
    .MAX_RETRY      (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .restart       (restart),
    .pll_lock      (pll_lock),
    .pll_rst       (pll_rst),
    .rstodiv       (rstodiv),
    .hs_rst        (hs_rst),
    .ready         (ready),
    .fail          (fail),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int k;
    int falls;
    int bad;
    logic prev;

    rst = 1'b1;
    restart = 1'b0;
    pll_lock = 1'b0;
    tick(3);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_rstodiv", rstodiv, 0);
    chk("rst_hs_rst", hs_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_lost", lock_lost_cnt, 0);

    // Test 1: nominal lock, pll_lock raised so that edge 10 after release samples it.
    rst = 1'b0;
    hi = 0;
    for (int t = 0; t < 10; t++) begin
      if (pll_rst) hi++;
      if (t == 9) pll_lock = 1'b1;
      tick();
    end
    chk("t1_pll_rst_cycles", hi, 4);
    chk("t1_pll_rst_low", pll_rst, 0);
    tick(8);
    chk("t1_e18_rstodiv", rstodiv, 0);
    chk("t1_e18_ready", ready, 0);
    tick();
    chk("t1_e19_rstodiv", rstodiv, 1);
    tick();
    chk("t1_e20_rstodiv", rstodiv, 1);
    chk("t1_e20_ready", ready, 0);
    chk("t1_e20_hs_rst", hs_rst, 1);
    tick();
    chk("t1_e21_rstodiv", rstodiv, 0);
    chk("t1_e21_ready", ready, 1);
    chk("t1_e21_hs_rst", hs_rst, 0);

    // Test 3 (first loss) then test 2 (glitch while qualifying at stable_cnt=5).
    pll_lock = 1'b0;
    tick(2);
    chk("t3_ready_before", ready, 1);
    tick();
    chk("t3_ready_drop", ready, 0);
    chk("t3_hs_rst_up", hs_rst, 1);
    chk("t3_pll_rst_up", pll_rst, 1);
    chk("t3_lost_one", lock_lost_cnt, 1);
    pll_lock = 1'b1;
    tick(4);
    chk("t3_pll_rst_release", pll_rst, 0);
    tick(3);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(2);
    chk("t2_no_early_odiv", rstodiv, 0);
    tick(7);
    chk("t2_f22_rstodiv", rstodiv, 0);
    tick();
    chk("t2_f23_rstodiv", rstodiv, 1);
    tick();
    chk("t2_f24_ready", ready, 0);
    tick();
    chk("t2_f25_ready", ready, 1);

    // Test 5a: restart coincident with loss-of-lock decision in RUN.
    pll_lock = 1'b0;
    tick(2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_restart_ready", ready, 0);
    chk("t5_restart_pll_rst", pll_rst, 1);
    chk("t5_restart_lost", lock_lost_cnt, 1);
    pll_lock = 1'b1;

    // Test 3: repeated losses up to 300 events, counter saturating at 255.
    for (int n = 2; n <= 300; n++) begin
      k = 0;
      while (ready !== 1'b1 && k < 60) begin
        tick();
        k++;
      end
      chk("t3_relock_ready", ready, 1);
      pll_lock = 1'b0;
      k = 0;
      while (ready !== 1'b0 && k < 10) begin
        tick();
        k++;
      end
      chk("t3_loss_ready", ready, 0);
      pll_lock = 1'b1;
      if (n == 254 || n == 255 || n == 256 || n == 300)
        chk("t3_lost_sat", lock_lost_cnt, (n > 255) ? 255 : n);
    end

    // Test 5b: rst asserted while in S_ODIV.
    k = 0;
    while (rstodiv !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk("t5_reach_odiv", rstodiv, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_pll_rst", pll_rst, 1);
    chk("t5_rst_rstodiv", rstodiv, 0);
    chk("t5_rst_hs_rst", hs_rst, 1);
    chk("t5_rst_ready", ready, 0);
    chk("t5_rst_fail", fail, 0);
    chk("t5_rst_lost", lock_lost_cnt, 0);

    // Test 4: lock never arrives -> three pll_rst pulses then sticky fail.
    pll_lock = 1'b0;
    tick(3);
    rst = 1'b0;
    falls = 0;
    prev = pll_rst;
    k = 0;
    while (fail !== 1'b1 && k < 200) begin
      tick();
      k++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
    end
    chk("t4_fail_cycle", k, 72);
    chk("t4_pulses", falls, 3);
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (pll_rst !== 1'b1 || fail !== 1'b1) bad++;
    end
    chk("t4_fail_sticky", bad, 0);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t4_restart_fail", fail, 0);
    chk("t4_restart_pll_rst", pll_rst, 1);
    tick(4);
    chk("t4_new_seq", pll_rst, 0);

    // Restart coincident with the first timeout: retry count must stay 0.
    tick(19);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_tmo_restart_pll_rst", pll_rst, 1);
    k = 0;
    while (fail !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("t5_tmo_restart_fail_cycle", k, 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
